// File: rtl/uart_hex_pkg.sv
// Shared types and ASCII constants for the UART hex command parser.
package uart_hex_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DIGITS   = 2'd1,
        HOLD     = 2'd2,
        DISCARD  = 2'd3
    } hex_state_t;

    typedef enum logic [1:0] {
        ERR_BAD_CHAR = 2'd0,
        ERR_OVERFLOW = 2'd1,
        ERR_FRAMING  = 2'd2,
        ERR_OVERRUN  = 2'd3
    } hex_err_t;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_SP = 8'h20;

    // Separator bytes tolerated between frames.
    function automatic logic is_blank(input logic [7:0] c);
        return (c == ASCII_CR) || (c == ASCII_LF) || (c == ASCII_SP);
    endfunction

endpackage

// File: rtl/hex_char_decode.sv
// Classifies one ASCII byte: hex digit value and letter case-folding.
module hex_char_decode (
    input  logic [7:0] ch,
    output logic       is_hex,
    output logic [3:0] nibble,
    output logic       is_letter,
    output logic [7:0] upper
);

    logic is_digit;
    logic is_up;
    logic is_low;
    logic is_af_up;
    logic is_af_low;

    always_comb begin
        is_digit  = (ch >= 8'h30) && (ch <= 8'h39);
        is_up     = (ch >= 8'h41) && (ch <= 8'h5A);
        is_low    = (ch >= 8'h61) && (ch <= 8'h7A);
        is_af_up  = (ch >= 8'h41) && (ch <= 8'h46);
        is_af_low = (ch >= 8'h61) && (ch <= 8'h66);

        is_hex    = is_digit || is_af_up || is_af_low;
        is_letter = is_up || is_low;

        nibble = 4'h0;
        if (is_digit) begin
            nibble = 4'(ch - 8'h30);
        end else if (is_af_up) begin
            nibble = 4'(ch - 8'h37);
        end else if (is_af_low) begin
            nibble = 4'(ch - 8'h57);
        end

        upper = is_low ? (ch - 8'h20) : ch;
    end

endmodule

// File: rtl/uart_hex_parser.sv
// Assembles "<letter><hex digits><CR>" frames from UART bytes into a command
// and binary operand, offered on a valid/ready handshake.
module uart_hex_parser
    import uart_hex_pkg::*;
#(
    parameter  int unsigned WIDTH = 32,
    localparam int unsigned NDW   = $clog2(WIDTH / 4 + 1)
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [7:0]       rx_data,
    input  logic             rx_done,
    input  logic             rx_err,
    output logic [7:0]       out_cmd,
    output logic [WIDTH-1:0] out_data,
    output logic [NDW-1:0]   out_ndigits,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err_valid,
    output logic [1:0]       err_code
);

    localparam int unsigned MAX_DIGITS = WIDTH / 4;

    hex_state_t       state;
    hex_state_t       state_d;
    hex_err_t         err_kind;
    logic             err_fire;
    logic             load_cmd;
    logic             shift_digit;
    logic             idle_rules;
    logic             full;

    logic [7:0]       cmd_d;
    logic [WIDTH-1:0] data_d;
    logic [NDW-1:0]   nd_d;
    logic             valid_d;
    logic             errv_d;
    logic [1:0]       ec_d;

    logic             c_is_hex;
    logic [3:0]       c_nibble;
    logic             c_is_letter;
    logic [7:0]       c_upper;

    hex_char_decode u_decode (
        .ch        (rx_data),
        .is_hex    (c_is_hex),
        .nibble    (c_nibble),
        .is_letter (c_is_letter),
        .upper     (c_upper)
    );

    // A handshake frees HOLD in the same cycle, so that cycle's byte follows the IDLE rules.
    assign idle_rules = (state == IDLE) || ((state == HOLD) && out_ready);
    assign full       = (out_ndigits == NDW'(MAX_DIGITS));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= IDLE;
            out_cmd     <= '0;
            out_data    <= '0;
            out_ndigits <= '0;
            out_valid   <= 1'b0;
            err_valid   <= 1'b0;
            err_code    <= '0;
        end else begin
            state       <= state_d;
            out_cmd     <= cmd_d;
            out_data    <= data_d;
            out_ndigits <= nd_d;
            out_valid   <= valid_d;
            err_valid   <= errv_d;
            err_code    <= ec_d;
        end
    end

    // Next state plus per-event actions; rx_err always takes priority over rx_done.
    always_comb begin
        state_d     = state;
        err_fire    = 1'b0;
        err_kind    = ERR_BAD_CHAR;
        load_cmd    = 1'b0;
        shift_digit = 1'b0;

        if (idle_rules) begin
            state_d = IDLE;
            if (rx_err) begin
                err_fire = 1'b1;
                err_kind = ERR_FRAMING;
                state_d  = DISCARD;
            end else if (rx_done) begin
                if (c_is_letter) begin
                    load_cmd = 1'b1;
                    state_d  = DIGITS;
                end else if (!is_blank(rx_data)) begin
                    err_fire = 1'b1;
                    state_d  = DISCARD;
                end
            end
        end else begin
            case (state)
                HOLD: begin
                    if (rx_err) begin
                        err_fire = 1'b1;
                        err_kind = ERR_FRAMING;
                    end else if (rx_done) begin
                        err_fire = 1'b1;
                        err_kind = ERR_OVERRUN;
                    end
                end
                DIGITS: begin
                    if (rx_err) begin
                        err_fire = 1'b1;
                        err_kind = ERR_FRAMING;
                        state_d  = DISCARD;
                    end else if (rx_done) begin
                        if (c_is_hex) begin
                            if (full) begin
                                err_fire = 1'b1;
                                err_kind = ERR_OVERFLOW;
                                state_d  = DISCARD;
                            end else begin
                                shift_digit = 1'b1;
                            end
                        end else if (rx_data == ASCII_CR) begin
                            state_d = HOLD;
                        end else begin
                            err_fire = 1'b1;
                            state_d  = DISCARD;
                        end
                    end
                end
                DISCARD: begin
                    if (rx_err) begin
                        err_fire = 1'b1;
                        err_kind = ERR_FRAMING;
                    end else if (rx_done && (rx_data == ASCII_CR)) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next values of the registered outputs.
    always_comb begin
        cmd_d   = out_cmd;
        data_d  = out_data;
        nd_d    = out_ndigits;
        valid_d = (state_d == HOLD);
        errv_d  = err_fire;
        ec_d    = err_code;

        if (err_fire) begin
            ec_d = err_kind;
        end
        if (load_cmd) begin
            cmd_d  = c_upper;
            data_d = '0;
            nd_d   = '0;
        end
        if (shift_digit) begin
            data_d = (out_data << 4) | WIDTH'(c_nibble);
            nd_d   = out_ndigits + NDW'(1);
        end
    end

endmodule

// File: tb/tb_uart_hex_parser.sv
// Bench for uart_hex_parser: decoder sweep, directed vector table, async reset
// mid-frame and random traffic against a frame-level reference model.
module tb_uart_hex_parser;

    localparam int unsigned WIDTH = 32;
    localparam int          MAXD  = WIDTH / 4;

    logic        clk = 1'b0;
    logic        nrst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_done = 1'b0;
    logic        rx_err = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  out_cmd;
    logic [31:0] out_data;
    logic [3:0]  out_ndigits;
    logic        out_valid;
    logic        err_valid;
    logic [1:0]  err_code;

    logic [7:0]  dch = 8'h00;
    logic        d_is_hex;
    logic [3:0]  d_nibble;
    logic        d_is_letter;
    logic [7:0]  d_upper;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a pending result, a frame being collected, or skipping to CR.
    logic        m_have;
    logic        m_collect;
    logic        m_drop;
    logic [7:0]  m_cmd;
    longint      m_val;
    int          m_n;
    logic        m_errv;
    logic [1:0]  m_ec;

    typedef struct {
        logic [7:0]  b;
        logic        d;
        logic        e;
        logic        r;
        logic [47:0] exp;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    uart_hex_parser #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .nrst        (nrst),
        .rx_data     (rx_data),
        .rx_done     (rx_done),
        .rx_err      (rx_err),
        .out_cmd     (out_cmd),
        .out_data    (out_data),
        .out_ndigits (out_ndigits),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .err_valid   (err_valid),
        .err_code    (err_code)
    );

    hex_char_decode u_dec (
        .ch        (dch),
        .is_hex    (d_is_hex),
        .nibble    (d_nibble),
        .is_letter (d_is_letter),
        .upper     (d_upper)
    );

    function automatic logic [47:0] dut_vec();
        return {out_valid, out_cmd, out_data, out_ndigits, err_valid, err_code};
    endfunction

    function automatic logic [47:0] model_vec();
        return {m_have, m_cmd, m_val[31:0], 4'(m_n), m_errv, m_ec};
    endfunction

    task automatic check(input string nm, input logic [47:0] got, input logic [47:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (valid,cmd,data,nd,errv,code)", nm, got, exp);
        end
    endtask

    function automatic logic letter(input logic [7:0] c);
        return ((c >= "A") && (c <= "Z")) || ((c >= "a") && (c <= "z"));
    endfunction

    function automatic logic [7:0] fold(input logic [7:0] c);
        return ((c >= "a") && (c <= "z")) ? c - 8'd32 : c;
    endfunction

    function automatic int hexval(input logic [7:0] c);
        string hs;
        hs = "0123456789ABCDEF";
        for (int n = 0; n < 16; n++) begin
            if (8'(hs[n]) == fold(c)) return n;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_have = 0; m_collect = 0; m_drop = 0;
        m_cmd = 8'h00; m_val = 0; m_n = 0; m_errv = 0; m_ec = 2'd0;
    endtask

    task automatic report(input int k);
        m_errv = 1'b1;
        m_ec   = 2'(k);
    endtask

    task automatic model_step(input logic [7:0] b, input logic d, input logic e, input logic r);
        int hv;
        hv = hexval(b);
        m_errv = 1'b0;
        if (m_have) begin
            if (!r) begin
                if (e) report(2);
                else if (d) report(3);
                return;
            end
            m_have = 1'b0;
        end
        if (!(d || e)) return;
        if (e) begin
            report(2);
            m_collect = 1'b0;
            m_drop = 1'b1;
            return;
        end
        if (m_drop) begin
            if (b == 8'h0D) m_drop = 1'b0;
            return;
        end
        if (m_collect) begin
            if (hv >= 0) begin
                if (m_n == MAXD) begin
                    report(1);
                    m_collect = 1'b0;
                    m_drop = 1'b1;
                end else begin
                    m_val = m_val * 16 + longint'(hv);
                    m_n++;
                end
            end else if (b == 8'h0D) begin
                m_collect = 1'b0;
                m_have = 1'b1;
            end else begin
                report(0);
                m_collect = 1'b0;
                m_drop = 1'b1;
            end
        end else if (letter(b)) begin
            m_cmd = fold(b);
            m_val = 0;
            m_n = 0;
            m_collect = 1'b1;
        end else if (!(b == 8'h0D || b == 8'h0A || b == 8'h20)) begin
            report(0);
            m_drop = 1'b1;
        end
    endtask

    // Drive one cycle of inputs, then compare against the model after the edge.
    task automatic apply(input string nm, input logic [7:0] b, input logic d, input logic e,
                         input logic r);
        rx_data = b; rx_done = d; rx_err = e; out_ready = r;
        @(posedge clk);
        #1;
        model_step(b, d, e, r);
        check(nm, dut_vec(), model_vec());
    endtask

    function automatic void add(input logic [7:0] b, input logic d, input logic e, input logic r,
                                input logic v, input logic [7:0] cmd, input logic [31:0] data,
                                input logic [3:0] nd, input logic ev, input logic [1:0] ec);
        vec_t t;
        t.b = b; t.d = d; t.e = e; t.r = r;
        t.exp = {v, cmd, data, nd, ev, ec};
        tbl.push_back(t);
    endfunction

    task automatic build_table();
        logic [31:0] acc;
        // valid frame, accepted immediately
        add("A", 1, 0, 1, 0, 8'h41, 32'h0, 0, 0, 0);
        add("1", 1, 0, 1, 0, 8'h41, 32'h1, 1, 0, 0);
        add("f", 1, 0, 1, 0, 8'h41, 32'h1F, 2, 0, 0);
        add("3", 1, 0, 1, 0, 8'h41, 32'h1F3, 3, 0, 0);
        add(8'h0D, 1, 0, 1, 1, 8'h41, 32'h1F3, 3, 0, 0);
        add(8'h00, 0, 0, 1, 0, 8'h41, 32'h1F3, 3, 0, 0);
        // full width
        add("x", 1, 0, 1, 0, 8'h58, 32'h0, 0, 0, 0);
        add("D", 1, 0, 1, 0, 8'h58, 32'hD, 1, 0, 0);
        add("E", 1, 0, 1, 0, 8'h58, 32'hDE, 2, 0, 0);
        add("A", 1, 0, 1, 0, 8'h58, 32'hDEA, 3, 0, 0);
        add("D", 1, 0, 1, 0, 8'h58, 32'hDEAD, 4, 0, 0);
        add("B", 1, 0, 1, 0, 8'h58, 32'hDEADB, 5, 0, 0);
        add("E", 1, 0, 1, 0, 8'h58, 32'hDEADBE, 6, 0, 0);
        add("E", 1, 0, 1, 0, 8'h58, 32'hDEADBEE, 7, 0, 0);
        add("F", 1, 0, 1, 0, 8'h58, 32'hDEADBEEF, 8, 0, 0);
        add(8'h0D, 1, 0, 1, 1, 8'h58, 32'hDEADBEEF, 8, 0, 0);
        add(8'h00, 0, 0, 1, 0, 8'h58, 32'hDEADBEEF, 8, 0, 0);
        // overflow on the ninth digit
        add("X", 1, 0, 1, 0, 8'h58, 32'h0, 0, 0, 0);
        acc = 32'h0;
        for (int i = 1; i <= 8; i++) begin
            acc = (acc << 4) | 32'(i);
            add(8'(8'h30 + i), 1, 0, 1, 0, 8'h58, acc, 4'(i), 0, 0);
        end
        add("9", 1, 0, 1, 0, 8'h58, 32'h12345678, 8, 1, 1);
        add(8'h0D, 1, 0, 1, 0, 8'h58, 32'h12345678, 8, 0, 1);
        // bad character, then an empty operand frame; blanks ignored in IDLE
        add("B", 1, 0, 1, 0, 8'h42, 32'h0, 0, 0, 1);
        add("1", 1, 0, 1, 0, 8'h42, 32'h1, 1, 0, 1);
        add("G", 1, 0, 1, 0, 8'h42, 32'h1, 1, 1, 0);
        add(8'h0D, 1, 0, 1, 0, 8'h42, 32'h1, 1, 0, 0);
        add(8'h0A, 1, 0, 1, 0, 8'h42, 32'h1, 1, 0, 0);
        add(8'h20, 1, 0, 1, 0, 8'h42, 32'h1, 1, 0, 0);
        add("C", 1, 0, 1, 0, 8'h43, 32'h0, 0, 0, 0);
        add(8'h0D, 1, 0, 1, 1, 8'h43, 32'h0, 0, 0, 0);
        add(8'h00, 0, 0, 1, 0, 8'h43, 32'h0, 0, 0, 0);
        // backpressure, overrun, and a byte arriving with the handshake
        add("D", 1, 0, 0, 0, 8'h44, 32'h0, 0, 0, 0);
        add(8'h0D, 1, 0, 0, 1, 8'h44, 32'h0, 0, 0, 0);
        add("E", 1, 0, 0, 1, 8'h44, 32'h0, 0, 1, 3);
        add(8'h00, 0, 0, 0, 1, 8'h44, 32'h0, 0, 0, 3);
        add("F", 1, 0, 1, 0, 8'h46, 32'h0, 0, 0, 3);
        add(8'h0D, 1, 0, 1, 1, 8'h46, 32'h0, 0, 0, 3);
        add(8'h00, 0, 0, 1, 0, 8'h46, 32'h0, 0, 0, 3);
        // framing errors mid-digits, in DISCARD, and together with rx_done
        add("G", 1, 0, 1, 0, 8'h47, 32'h0, 0, 0, 3);
        add("5", 1, 0, 1, 0, 8'h47, 32'h5, 1, 0, 3);
        add(8'h00, 0, 1, 1, 0, 8'h47, 32'h5, 1, 1, 2);
        add("7", 1, 0, 1, 0, 8'h47, 32'h5, 1, 0, 2);
        add(8'h00, 0, 1, 1, 0, 8'h47, 32'h5, 1, 1, 2);
        add(8'h0D, 1, 0, 1, 0, 8'h47, 32'h5, 1, 0, 2);
        add("H", 1, 1, 1, 0, 8'h47, 32'h5, 1, 1, 2);
        add(8'h0D, 1, 0, 1, 0, 8'h47, 32'h5, 1, 0, 2);
        add("i", 1, 0, 1, 0, 8'h49, 32'h0, 0, 0, 2);
        add(8'h0D, 1, 0, 1, 1, 8'h49, 32'h0, 0, 0, 2);
        add(8'h00, 0, 0, 1, 0, 8'h49, 32'h0, 0, 0, 2);
    endtask

    function automatic logic [7:0] rand_byte();
        string pool;
        int    k;
        pool = "0123456789abcdefABCDEF";
        k = int'($urandom_range(0, 9));
        if (k <= 3) return 8'(pool[$urandom_range(0, 21)]);
        if (k == 4) return 8'(8'h41 + 8'($urandom_range(0, 25)));
        if (k == 5) return 8'(8'h61 + 8'($urandom_range(0, 25)));
        if (k <= 7) return 8'h0D;
        if (k == 8) return ($urandom_range(0, 1) == 0) ? 8'h0A : 8'h20;
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        logic [13:0] dgot;
        logic [13:0] dexp;
        int          hv;
        logic        lt;

        // decoder sweep over every byte value
        for (int i = 0; i < 256; i++) begin
            dch = 8'(i);
            #1;
            hv = hexval(8'(i));
            lt = letter(8'(i));
            dgot = {d_is_hex, d_is_hex ? d_nibble : 4'h0, d_is_letter, d_is_letter ? d_upper : 8'h00};
            dexp = {hv >= 0, (hv >= 0) ? 4'(hv) : 4'h0, lt, lt ? fold(8'(i)) : 8'h00};
            check("decode", 48'(dgot), 48'(dexp));
        end

        nrst = 1'b0;
        #2;
        check("reset_state", dut_vec(), 48'h0);
        model_reset();
        @(negedge clk);
        nrst = 1'b1;

        build_table();
        foreach (tbl[i]) begin
            apply("table_model", tbl[i].b, tbl[i].d, tbl[i].e, tbl[i].r);
            check("table_vec", dut_vec(), tbl[i].exp);
        end

        // async reset between edges with a partial frame in flight
        apply("rst_a", "A", 1, 0, 1);
        apply("rst_1", "1", 1, 0, 1);
        apply("rst_2", "2", 1, 0, 1);
        #2;
        nrst = 1'b0;
        #1;
        check("async_reset", dut_vec(), 48'h0);
        model_reset();
        @(negedge clk);
        nrst = 1'b1;
        apply("post_rst_b", "B", 1, 0, 0);
        apply("post_rst_cr", 8'h0D, 1, 0, 0);
        check("post_rst_result", dut_vec(), {1'b1, 8'h42, 32'h0, 4'h0, 1'b0, 2'd0});
        apply("post_rst_ack", 8'h00, 0, 0, 1);

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            apply("random", rand_byte(), ($urandom_range(0, 9) < 7), ($urandom_range(0, 24) == 0),
                  ($urandom_range(0, 2) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
